// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered
// segments, with valid/ready on both sides and one operation per cycle.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int INC    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;

    // Bit offset of stage k's pending (not yet added) B operand bits in bp_q.
    function automatic int bp_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += SEG * (STAGES - 1 - j);
        return o;
    endfunction

    localparam int BPT = bp_off(STAGES - 1);
    localparam int BPW = (BPT > 0) ? BPT : 1;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // All stages advance together when the output slot is empty or being
    // drained (en); otherwise the whole pipe holds. Flush kills every stage
    // and refuses the input offered in the same cycle.
    logic                         en;
    logic                         accept;
    logic [WIDTH-1:0]             b_sel;
    logic [WIDTH-1:0]             b_eff;
    logic [STAGES-1:0]            v_q, v_n;
    logic [STAGES-1:0]            c_q, c_n;
    logic [STAGES-1:0][WIDTH-1:0] aw_q, aw_n;
    logic [BPW-1:0]               bp_q, bp_n;
    logic                         ovf_q, ovf_n;
    logic                         zero_q, zero_n;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !flush;
    assign accept   = in_valid && in_ready;

    assign b_sel = mode[1] ? WIDTH'(INC) : in2;
    assign b_eff = mode[0] ? ~b_sel : b_sel;

    // aw_q[k] holds the finished result bits below the segment boundary and
    // the still-pending A bits above it, so one word travels per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int BW = WIDTH - k * SEG;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] a_new;
        logic [BW-1:0]    b_in;
        logic             c_in;
        logic [SEG:0]     sum;

        if (k == 0) begin : g_first
            assign a_in   = in1;
            assign b_in   = b_eff;
            assign c_in   = mode[0];
            assign v_n[0] = accept;
        end else begin : g_next
            assign a_in   = aw_q[k-1];
            assign b_in   = bp_q[bp_off(k-1) +: BW];
            assign c_in   = c_q[k-1];
            assign v_n[k] = v_q[k-1];
        end

        assign sum = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        always_comb begin
            a_new = a_in;
            a_new[k*SEG +: SEG] = sum[SEG-1:0];
        end

        assign aw_n[k] = a_new;
        assign c_n[k]  = sum[SEG];

        if (k < STAGES - 1) begin : g_pend
            assign bp_n[bp_off(k) +: BW - SEG] = b_in[BW-1:SEG];
        end else begin : g_last
            assign ovf_n  = (a_in[WIDTH-1] == b_in[BW-1]) && (sum[SEG-1] != a_in[WIDTH-1]);
            assign zero_n = ~|a_new;
        end
    end

    if (STAGES == 1) begin : g_no_pend
        assign bp_n = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q    <= '0;
            c_q    <= '0;
            aw_q   <= '0;
            bp_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (en) begin
                v_q    <= v_n;
                c_q    <= c_n;
                aw_q   <= aw_n;
                bp_q   <= bp_n;
                ovf_q  <= ovf_n;
                zero_q <= zero_n;
            end
            if (flush) v_q <= '0;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out       = aw_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (STAGES = 2, 1, 4) driven with
// hand-computed vectors; a negedge monitor pops expected results per instance.
module tb_pipelined_addsub;
    localparam int W  = 35;
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2;
    logic [1:0]  mode;
    logic        iv[3], ir[3], ov[3], ordy[3], fl[3], cy[3], of[3], zr[3];
    logic [31:0] o[3];

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];
    int tests = 0;
    int fails = 0;
    int lat[3] = '{2, 1, 4};

    // Vector table: mode, A, B, expected {out, carry, overflow, zero}.
    logic [1:0]   vm[NV] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10,
                             2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11};
    logic [31:0]  va[NV] = '{32'd10, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd7,
                             32'h80000000, 32'd128, 32'd128, 32'hFFFFFFFC, 32'd0,
                             32'd3, 32'h0000FFFF, 32'h80000000, 32'h80000003};
    logic [31:0]  vb[NV] = '{32'd128, 32'd1, 32'd1, 32'd7, 32'd5, 32'd1,
                             32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'd0,
                             32'd3, 32'd1, 32'h80000000, 32'd0};
    logic [W-1:0] ve[NV] = '{{32'd138, 3'b000}, {32'd0, 3'b101},
                             {32'h80000000, 3'b010}, {32'hFFFFFFFE, 3'b000},
                             {32'd2, 3'b100}, {32'h7FFFFFFF, 3'b110},
                             {32'd132, 3'b000}, {32'd124, 3'b100},
                             {32'd0, 3'b101}, {32'hFFFFFFFC, 3'b000},
                             {32'd0, 3'b101}, {32'h00010000, 3'b000},
                             {32'd0, 3'b111}, {32'h7FFFFFFF, 3'b110}};

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(2), .INC(4)) dut_s2 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in1(in1),
        .in2(in2), .mode(mode), .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(o[0]), .carry(cy[0]), .overflow(of[0]), .zero(zr[0]));

    pipelined_addsub #(.WIDTH(32), .STAGES(1), .INC(4)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in1(in1),
        .in2(in2), .mode(mode), .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(o[1]), .carry(cy[1]), .overflow(of[1]), .zero(zr[1]));

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .INC(4)) dut_s4 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in1(in1),
        .in2(in2), .mode(mode), .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out(o[2]), .carry(cy[2]), .overflow(of[2]), .zero(zr[2]));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic qpush(input int d, input logic [W-1:0] e);
        case (d)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    function automatic logic [W-1:0] qpop(input int d);
        case (d)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic qclear(input int d);
        case (d)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    // Monitor: every output transfer is compared against the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (qsize(d) == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out_d%0d: got %h, expected no output",
                                 d, {o[d], cy[d], of[d], zr[d]});
                    end else begin
                        check($sformatf("result_d%0d", d), {o[d], cy[d], of[d], zr[d]}, qpop(d));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int i);
        in1   = va[i];
        in2   = vb[i];
        mode  = vm[i];
        iv[d] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ir[d]) begin
                qpush(d, ve[i]);
                step();
                iv[d] = 1'b0;
                return;
            end
            step();
        end
        iv[d] = 1'b0;
        tests++;
        fails++;
        $display("FAIL send_timeout_d%0d: vector %0d in_ready got 0 for 40 cycles, expected 1", d, i);
    endtask

    task automatic check_latency(input int d);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ov[d]) break;
        end
        check($sformatf("latency_d%0d", d), n, lat[d]);
        step();
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((qsize(d) != 0 || ov[d]) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout_d%0d: got %0d pending results, expected 0", d, qsize(d));
        end
        step();
    endtask

    task automatic stream(input int d, input int first, input int last);
        fork
            begin
                for (int i = first; i <= last; i++) send(d, i);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!ov[d] && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("stream_start_d%0d", d), ov[d], 1'b1);
                for (int k = 1; k <= last - first; k++) begin
                    @(negedge clk);
                    check($sformatf("stream_gap_d%0d_%0d", d, k), ov[d], 1'b1);
                end
            end
        join
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got no end by 100000, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        in1   = '0;
        in2   = '0;
        mode  = '0;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            fl[d]   = 1'b0;
            ordy[d] = 1'b1;
        end

        // Reset state
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_out_valid_d%0d", d), ov[d], 1'b0);
            check($sformatf("reset_out_d%0d", d), {o[d], cy[d], of[d], zr[d]}, '0);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("reset_in_ready_d%0d", d), ir[d], 1'b1);
        step();

        // STAGES=2: latency, then a mixed-mode back-to-back stream
        send(0, 0);
        check_latency(0);
        drain(0);
        stream(0, 1, 13);
        drain(0);

        // Backpressure with a full pipe for three cycles
        ordy[0] = 1'b0;
        send(0, 0);
        send(0, 1);
        fork
            send(0, 2);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", ir[0], 1'b0);
                    check("stall_out_valid", ov[0], 1'b1);
                    check("stall_out_hold", {o[0], cy[0], of[0], zr[0]}, ve[0]);
                end
                step();
                ordy[0] = 1'b1;
            end
        join
        drain(0);

        // Flush with two operations in flight and a third offered
        ordy[0] = 1'b0;
        send(0, 3);
        send(0, 4);
        fl[0] = 1'b1;
        iv[0] = 1'b1;
        in1   = va[5];
        in2   = vb[5];
        mode  = vm[5];
        @(negedge clk);
        check("flush_in_ready", ir[0], 1'b0);
        step();
        fl[0]   = 1'b0;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        qclear(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("flush_out_valid_%0d", k), ov[0], 1'b0);
        end
        step();

        // Reset asserted mid-stream clears outputs without waiting for a clock
        send(0, 11);
        send(0, 12);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", ov[0], 1'b0);
        check("midrst_out", o[0], 32'd0);
        check("midrst_flags", {cy[0], of[0], zr[0]}, 3'b000);
        qclear(0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", ir[0], 1'b1);
        check("midrst_out_valid_after", ov[0], 1'b0);
        step();

        // STAGES=1 and STAGES=4
        for (int d = 1; d < 3; d++) begin
            send(d, 0);
            check_latency(d);
            drain(d);
            stream(d, 1, 13);
            drain(d);
        end

        for (int d = 0; d < 3; d++) check($sformatf("queue_empty_d%0d", d), qsize(d), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
